// File: rtl/hazard_forward_ctrl_if.sv
// Operand-forwarding / hazard control bundle between the pipeline and hazard_forward_ctrl.
interface hazard_forward_ctrl_if #(
  parameter int RA_W    = 5,
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC*RA_W-1:0] rs_ex_i;
  logic [RA_W-1:0]         rd_exme_i;
  logic                    regwrite_exme_i;
  logic [RA_W-1:0]         rd_mewb_i;
  logic                    regwrite_mewb_i;
  logic                    valid_id_i;
  logic [NUM_SRC*RA_W-1:0] rs_id_i;
  logic                    long_id_i;
  logic                    memread_ex_i;
  logic [RA_W-1:0]         rd_ex_i;
  logic                    long_issue_i;
  logic [2*NUM_SRC-1:0]    fwd_sel_o;
  logic                    stall_o;
  logic                    bubble_o;
  logic                    long_busy_o;
  logic                    long_wb_o;

  modport master (
    output rs_ex_i, rd_exme_i, regwrite_exme_i, rd_mewb_i, regwrite_mewb_i,
           valid_id_i, rs_id_i, long_id_i, memread_ex_i, rd_ex_i, long_issue_i,
    input  fwd_sel_o, stall_o, bubble_o, long_busy_o, long_wb_o
  );

  modport slave (
    input  rs_ex_i, rd_exme_i, regwrite_exme_i, rd_mewb_i, regwrite_mewb_i,
           valid_id_i, rs_id_i, long_id_i, memread_ex_i, rd_ex_i, long_issue_i,
    output fwd_sel_o, stall_o, bubble_o, long_busy_o, long_wb_o
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// EX operand forwarding, load-use detection and single long-op (mul/div) tracker.
// Optional HAZARD_PERF_EN adds saturating stall/long-hazard cycle counters.
module hazard_forward_ctrl #(
  parameter int RA_W     = 5,
  parameter int NUM_SRC  = 2,
  parameter int LONG_LAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_forward_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         bubble_cnt_o
`endif
);

  localparam int CNT_W = (LONG_LAT > 2) ? $clog2(LONG_LAT) : 1;
  // The issue cycle itself counts as the first latency cycle, so the
  // register holds one less and long_wb_o lands LONG_LAT-1 cycles after issue.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LONG_LAT - 2);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RA_W-1:0]  lrd_q, lrd_d;

  logic [NUM_SRC-1:0][1:0] fwd_sel;
  logic lu_hit, lrd_hit, load_use, long_haz, busy, stall;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [RA_W-1:0] rs;
    assign rs = bus.rs_ex_i[k*RA_W +: RA_W];
    // rs != 0 plus equality also excludes rd == 0 as a source
    always_comb begin
      fwd_sel[k] = 2'b00;
      if (rs != '0) begin
        if (bus.regwrite_exme_i && bus.rd_exme_i == rs)      fwd_sel[k] = 2'b10;
        else if (bus.regwrite_mewb_i && bus.rd_mewb_i == rs) fwd_sel[k] = 2'b01;
      end
    end
  end
  assign bus.fwd_sel_o = fwd_sel;

  always_comb begin
    lu_hit  = 1'b0;
    lrd_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.rs_id_i[k*RA_W +: RA_W] == bus.rd_ex_i) lu_hit  = 1'b1;
      if (bus.rs_id_i[k*RA_W +: RA_W] == lrd_q)       lrd_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lrd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lrd_q   <= lrd_d;
    end
  end

  // An issue while cnt != 0 is a protocol error and leaves the tracker untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lrd_d   = lrd_q;
    case (state_q)
      IDLE: if (bus.long_issue_i) begin
        state_d = BUSY;
        cnt_d   = CNT_LOAD;
        lrd_d   = bus.rd_ex_i;
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (bus.long_issue_i) begin
          cnt_d = CNT_LOAD;
          lrd_d = bus.rd_ex_i;
        end else begin
          state_d = IDLE;
          lrd_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == BUSY);
  assign load_use = bus.valid_id_i && bus.memread_ex_i && (bus.rd_ex_i != '0) && lu_hit;
  // RAW stall holds through the writeback cycle; the regfile is readable the cycle after.
  assign long_haz = busy && bus.valid_id_i &&
                    (((lrd_q != '0) && lrd_hit) || (bus.long_id_i && (cnt_q != '0)));
  assign stall    = rst_n && (load_use || long_haz);

  assign bus.stall_o     = stall;
  assign bus.bubble_o    = stall;
  assign bus.long_busy_o = busy;
  assign bus.long_wb_o   = busy && (cnt_q == '0);

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (stall && stall_cnt_o != '1)     stall_cnt_o  <= stall_cnt_o + 32'd1;
      if (long_haz && bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule
